// File: rtl/sir_regfile_pkg.sv
// Shared definitions for the sir_regfile CSR responder: register offsets,
// the unmapped-read pattern, FSM state encoding and the error counter width.
package sir_regfile_pkg;

    localparam logic [7:0] OFF_VERSION   = 8'h00;
    localparam logic [7:0] OFF_SCRATCH   = 8'h04;
    localparam logic [7:0] OFF_CTRL      = 8'h08;
    localparam logic [7:0] OFF_STATUS    = 8'h0C;
    localparam logic [7:0] OFF_IRQ_STAT  = 8'h10;
    localparam logic [7:0] OFF_IRQ_EN    = 8'h14;
    localparam logic [7:0] OFF_TIMESTAMP = 8'h18;
    localparam logic [7:0] OFF_ERR_CNT   = 8'h1C;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    localparam int ERR_W = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_LATCH = 4'b0010,
        ST_RESP  = 4'b0100,
        ST_HOLD  = 4'b1000
    } sir_state_e;

endpackage

// File: rtl/sir_irq_bank.sv
// Interrupt status (W1C, set-wins) and enable registers with a registered
// interrupt level output.
module sir_irq_bank #(
    parameter int IRQ_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] irq_src,
    input  logic             stat_we,
    input  logic             en_we,
    input  logic [IRQ_W-1:0] wdat,
    output logic [IRQ_W-1:0] irq_stat,
    output logic [IRQ_W-1:0] irq_en,
    output logic             irq
);

    logic [IRQ_W-1:0] stat_d, stat_q;
    logic [IRQ_W-1:0] en_d, en_q;
    logic             irq_d, irq_q;

    always_comb begin
        stat_d = stat_q;
        if (stat_we) begin
            stat_d = stat_q & ~wdat;
        end
        // A set pulse in the same cycle as a clear keeps the bit set.
        stat_d = stat_d | irq_src;
        en_d   = en_we ? wdat : en_q;
        irq_d  = |(stat_q & en_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
            en_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= stat_d;
            en_q   <= en_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_stat = stat_q;
    assign irq_en   = en_q;
    assign irq      = irq_q;

endmodule

// File: rtl/sir_regfile.sv
// Register-bank responder for one 256-byte sir_* CSR window. Each sir_sel
// assertion yields exactly one access. Optional counter: SIR_REGFILE_TIMESTAMP_EN.
module sir_regfile
    import sir_regfile_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] VERSION   = 32'h0001_0000,
    parameter int          IRQ_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sir_sel,
    input  logic [31:0]      sir_addr,
    input  logic             sir_read,
    input  logic [31:0]      sir_wdat,
    output logic [31:0]      sir_rdat,
    output logic             sir_dack,
    input  logic [31:0]      sts_in,
    input  logic [IRQ_W-1:0] irq_src,
    output logic [15:0]      ctrl_out,
    output logic             irq
);

    sir_state_e  state_q;
    logic        dack_q;
    logic [31:2] addr_q;
    logic        read_q;
    logic [31:0] wdat_q;

    // Access sequencer; the address/data are captured once in IDLE so a long
    // sir_sel cannot retrigger until it has been seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dack_q  <= 1'b0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            wdat_q  <= '0;
        end else begin
            dack_q <= (state_q == ST_RESP);
            case (state_q)
                ST_IDLE: begin
                    if (sir_sel) begin
                        addr_q  <= sir_addr[31:2];
                        read_q  <= sir_read;
                        wdat_q  <= sir_wdat;
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: state_q <= ST_RESP;
                ST_RESP:  state_q <= ST_HOLD;
                ST_HOLD: begin
                    if (!sir_sel) begin
                        state_q <= ST_IDLE;
                    end
                end
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    logic [7:0]       off;
    logic             base_hit;
    logic             hit;
    logic             commit;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic [31:0]      scratch_d, scratch_q;
    logic [15:0]      ctrl_d, ctrl_q;
    logic [ERR_W-1:0] err_d, err_q;
    logic [31:0]      rdat_d, rdat_q;
    logic [IRQ_W-1:0] irq_stat;
    logic [IRQ_W-1:0] irq_en;
    logic [31:0]      ts_val;

`ifdef SIR_REGFILE_TIMESTAMP_EN
    logic [31:0] ts_d, ts_q;

    always_comb begin
        ts_d = ts_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign ts_val = ts_q;
`else
    assign ts_val = '0;
`endif

    always_comb begin
        off      = {addr_q[7:2], 2'b00};
        base_hit = (addr_q[31:8] == BASE_ADDR[31:8]);
        hit      = base_hit && (off < 8'h20);
        commit   = (state_q == ST_LATCH);
        wr_en    = commit && !read_q && hit;

        rd_mux = UNMAPPED_RDATA;
        if (hit) begin
            rd_mux = '0;
            case (off)
                OFF_VERSION:   rd_mux = VERSION;
                OFF_SCRATCH:   rd_mux = scratch_q;
                OFF_CTRL:      rd_mux[15:0] = ctrl_q;
                OFF_STATUS:    rd_mux = sts_in;
                OFF_IRQ_STAT:  rd_mux[IRQ_W-1:0] = irq_stat;
                OFF_IRQ_EN:    rd_mux[IRQ_W-1:0] = irq_en;
                OFF_TIMESTAMP: rd_mux = ts_val;
                OFF_ERR_CNT:   rd_mux[ERR_W-1:0] = err_q;
                default:       rd_mux = UNMAPPED_RDATA;
            endcase
        end

        scratch_d = (wr_en && off == OFF_SCRATCH) ? wdat_q : scratch_q;
        ctrl_d    = (wr_en && off == OFF_CTRL) ? wdat_q[15:0] : ctrl_q;
        rdat_d    = (commit && read_q) ? rd_mux : rdat_q;

        err_d = err_q;
        if (commit && !hit) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + 1'b1;
            end
        end else if (wr_en && off == OFF_ERR_CNT) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch_q <= '0;
            ctrl_q    <= '0;
            err_q     <= '0;
            rdat_q    <= '0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
        end
    end

    sir_irq_bank #(
        .IRQ_W(IRQ_W)
    ) u_irq_bank (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .stat_we  (wr_en && off == OFF_IRQ_STAT),
        .en_we    (wr_en && off == OFF_IRQ_EN),
        .wdat     (wdat_q[IRQ_W-1:0]),
        .irq_stat (irq_stat),
        .irq_en   (irq_en),
        .irq      (irq)
    );

    assign sir_rdat = rdat_q;
    assign sir_dack = dack_q;
    assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_sir_regfile.sv
// Directed bench for sir_regfile: a table of single accesses followed by
// hand-written interrupt, mid-access reset and timestamp sequences.
module tb_sir_regfile;

    localparam logic [31:0] VER = 32'h0001_0000;
    localparam logic [31:0] STS = 32'hCAFE_0123;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sir_sel = 1'b0;
    logic [31:0] sir_addr = '0;
    logic        sir_read = 1'b0;
    logic [31:0] sir_wdat = '0;
    logic [31:0] sir_rdat;
    logic        sir_dack;
    logic [31:0] sts_in = STS;
    logic [7:0]  irq_src = '0;
    logic [15:0] ctrl_out;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sir_regfile #(
        .BASE_ADDR(32'h0000_0000),
        .VERSION  (VER),
        .IRQ_W    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sir_sel  (sir_sel),
        .sir_addr (sir_addr),
        .sir_read (sir_read),
        .sir_wdat (sir_wdat),
        .sir_rdat (sir_rdat),
        .sir_dack (sir_dack),
        .sts_in   (sts_in),
        .irq_src  (irq_src),
        .ctrl_out (ctrl_out),
        .irq      (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access; sir_sel stays high for sel_cycles edges starting at edge N.
    // dack_at is the edge offset after which sir_dack was first seen high.
    task automatic access(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                          input int sel_cycles, input logic pulse0,
                          output logic [31:0] rdat, output int dack_cnt,
                          output int dack_at, output logic [15:0] ctrl_n1);
        @(negedge clk);
        sir_sel  = 1'b1;
        sir_addr = a;
        sir_read = rd;
        sir_wdat = wd;
        dack_cnt = 0;
        dack_at  = -1;
        ctrl_n1  = '0;
        for (int c = 0; c < sel_cycles + 6; c++) begin
            @(posedge clk);
            #1;
            if (sir_dack) begin
                dack_cnt++;
                if (dack_at < 0) dack_at = c;
            end
            if (c == 1) ctrl_n1 = ctrl_out;
            if (pulse0 && c == 0) irq_src = 8'h01;
            if (c == 1) irq_src = 8'h00;
            if (c == sel_cycles - 1) sir_sel = 1'b0;
        end
        rdat = sir_rdat;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        int dc, da;
        logic [15:0] cn;
        access(a, 1'b1, 32'h0, 1, 1'b0, r, dc, da, cn);
        chk(name, r, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic pulse0);
        logic [31:0] r;
        int dc, da;
        logic [15:0] cn;
        access(a, 1'b0, d, 2, pulse0, r, dc, da, cn);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdat;
        int          sel_cycles;
        logic [31:0] exp_rdat;
        logic [15:0] exp_ctrl;
    } vec_t;

    vec_t vecs[23];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int dc, da;
        logic [15:0] cn;
        logic [31:0] t0, t1;

        vecs[0]  = '{32'h0000_0000, 1'b1, 32'h0,         1,  VER,           16'h0};
        vecs[1]  = '{32'h0000_0008, 1'b1, 32'h0,         2,  32'h0,         16'h0};
        vecs[2]  = '{32'h0000_0010, 1'b1, 32'h0,         1,  32'h0,         16'h0};
        vecs[3]  = '{32'h0000_0004, 1'b0, 32'hA5A5_5A5A, 13, 32'h0,         16'h0};
        vecs[4]  = '{32'h0000_0004, 1'b1, 32'h0,         1,  32'hA5A5_5A5A, 16'h0};
        vecs[5]  = '{32'h0000_0008, 1'b0, 32'h1234_ABCD, 2,  32'hA5A5_5A5A, 16'hABCD};
        vecs[6]  = '{32'h0000_0008, 1'b1, 32'h0,         1,  32'h0000_ABCD, 16'hABCD};
        vecs[7]  = '{32'h0000_000C, 1'b1, 32'h0,         3,  STS,           16'hABCD};
        vecs[8]  = '{32'h0000_0040, 1'b1, 32'h0,         1,  32'hDEAD_BEEF, 16'hABCD};
        vecs[9]  = '{32'h1000_0004, 1'b1, 32'h0,         1,  32'hDEAD_BEEF, 16'hABCD};
        vecs[10] = '{32'h0000_001C, 1'b1, 32'h0,         1,  32'h2,         16'hABCD};
        vecs[11] = '{32'h0000_001C, 1'b0, 32'h0,         1,  32'h2,         16'hABCD};
        vecs[12] = '{32'h0000_001F, 1'b1, 32'h0,         1,  32'h0,         16'hABCD};
        vecs[13] = '{32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1,  32'h0,         16'hABCD};
        vecs[14] = '{32'h0000_0000, 1'b1, 32'h0,         1,  VER,           16'hABCD};
        vecs[15] = '{32'h0000_0044, 1'b0, 32'hFFFF_FFFF, 1,  VER,           16'hABCD};
        vecs[16] = '{32'h0000_0006, 1'b1, 32'h0,         1,  32'hA5A5_5A5A, 16'hABCD};
        vecs[17] = '{32'h0000_001C, 1'b1, 32'h0,         1,  32'h1,         16'hABCD};
        vecs[18] = '{32'h0000_0018, 1'b0, 32'h0,         1,  32'h1,         16'hABCD};
        vecs[19] = '{32'h0000_001C, 1'b1, 32'h0,         1,  32'h1,         16'hABCD};
        vecs[20] = '{32'h0000_001C, 1'b0, 32'h0,         1,  32'h1,         16'hABCD};
        vecs[21] = '{32'h0000_0014, 1'b0, 32'hFFFF_FF01, 1,  32'h1,         16'hABCD};
        vecs[22] = '{32'h0000_0014, 1'b1, 32'h0,         1,  32'h0000_0001, 16'hABCD};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_rdat", sir_rdat, 32'h0);
        chk("reset_dack", {31'h0, sir_dack}, 32'h0);
        chk("reset_ctrl", {16'h0, ctrl_out}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        foreach (vecs[i]) begin
            access(vecs[i].addr, vecs[i].rd, vecs[i].wdat, vecs[i].sel_cycles, 1'b0,
                   r, dc, da, cn);
            chk($sformatf("vec%0d_rdat", i), r, vecs[i].exp_rdat);
            chk($sformatf("vec%0d_dack_cnt", i), dc, 32'd1);
            chk($sformatf("vec%0d_dack_at", i), da, 32'd2);
            chk($sformatf("vec%0d_ctrl_n1", i), {16'h0, cn}, {16'h0, vecs[i].exp_ctrl});
        end

        // Interrupts: IRQ_EN = 0x01 from the table. Source 1 is not enabled.
        @(negedge clk);
        irq_src = 8'h02;
        @(negedge clk);
        irq_src = 8'h00;
        repeat (3) @(negedge clk);
        chk("irq_masked", {31'h0, irq}, 32'h0);

        // Pulse source 0: status sets at edge E, irq rises one edge later.
        irq_src = 8'h01;
        @(posedge clk);
        #1;
        chk("irq_lat_e", {31'h0, irq}, 32'h0);
        @(negedge clk);
        irq_src = 8'h00;
        @(posedge clk);
        #1;
        chk("irq_lat_e1", {31'h0, irq}, 32'h1);
        rd_chk("irq_stat_both", 32'h10, 32'h3);

        // W1C on bit 0 colliding with a new pulse: set wins.
        wr(32'h10, 32'h1, 1'b1);
        chk("irq_set_wins", {31'h0, irq}, 32'h1);
        rd_chk("irq_stat_after_clash", 32'h10, 32'h3);
        wr(32'h10, 32'h1, 1'b0);
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        rd_chk("irq_stat_after_w1c", 32'h10, 32'h2);

        // Reset before edge N+1 of a SCRATCH write: no commit, no dack.
        @(negedge clk);
        sir_sel  = 1'b1;
        sir_addr = 32'h4;
        sir_read = 1'b0;
        sir_wdat = 32'h1111_2222;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        dc = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (sir_dack) dc++;
        end
        sir_sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_no_dack", dc, 32'd0);
        chk("rst_mid_ctrl", {16'h0, ctrl_out}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_post_dack", {31'h0, sir_dack}, 32'h0);
        rd_chk("rst_mid_scratch", 32'h4, 32'h0);
        rd_chk("rst_mid_irq_stat", 32'h10, 32'h0);

        // TIMESTAMP: two reads with starting edges 10 cycles apart.
        access(32'h18, 1'b1, 32'h0, 4, 1'b0, t0, dc, da, cn);
        access(32'h18, 1'b1, 32'h0, 4, 1'b0, t1, dc, da, cn);
`ifdef SIR_REGFILE_TIMESTAMP_EN
        chk("ts_delta", t1 - t0, 32'd10);
`else
        chk("ts_absent0", t0, 32'h0);
        chk("ts_absent1", t1, 32'h0);
`endif
        rd_chk("ts_not_unmapped", 32'h1C, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
